// File: rtl/s2a_pkg.sv
// Shared definitions for the S2A sample packer: FSM encoding, packing-mode
// constants and counter widths.
package s2a_pkg;

   typedef enum logic [1:0] {
      IDLE       = 2'd0,
      WAIT_FRAME = 2'd1,
      RUN        = 2'd2
   } state_t;

   localparam logic MODE_16 = 1'b0;
   localparam logic MODE_8  = 1'b1;

   localparam int SCNT_W = 32;
   localparam int SAT_W  = 16;
   localparam int WORD_W = 32;

endpackage

// File: rtl/s2a_packer_if.sv
// Sample-in / packed-word-out bus between the sample source, the packer and
// the downstream S2A controller.
interface s2a_packer_if #(
   parameter int IW = 12
);

   logic          in_valid;
   logic [IW-1:0] in_i;
   logic [IW-1:0] in_q;
   logic          in_frame;
   logic [31:0]   Odata;
   logic          Oen;

   modport master (
      output in_valid, in_i, in_q, in_frame,
      input  Odata, Oen
   );

   modport slave (
      input  in_valid, in_i, in_q, in_frame,
      output Odata, Oen
   );

endinterface

// File: rtl/s2a_packer_iq_round_sat.sv
// Combinational reduction of one IW-bit two's-complement component to a
// rounded, saturated signed byte plus a flag raised when clipping occurred.
module iq_round_sat
   import s2a_pkg::*;
#(
   parameter int IW = 12
) (
   input  logic [IW-1:0] i_x,
   output logic [7:0]    o_x8,
   output logic          o_sat
);

   // One guard bit on top of IW keeps the rounding add from overflowing.
   localparam logic signed [IW:0] ROUND = (IW+1)'(1) << (IW-9);
   localparam logic signed [IW:0] MAXV  = (IW+1)'(127);
   localparam logic signed [IW:0] MINV  = -(IW+1)'(128);

   logic signed [IW:0] w_sum;
   logic signed [IW:0] w_shift;

   always_comb begin
      w_sum   = $signed({i_x[IW-1], i_x}) + ROUND;
      w_shift = w_sum >>> (IW-8);
      o_sat   = 1'b0;
      o_x8    = w_shift[7:0];
      if (w_shift > MAXV) begin
         o_sat = 1'b1;
         o_x8  = 8'h7F;
      end else if (w_shift < MINV) begin
         o_sat = 1'b1;
         o_x8  = 8'h80;
      end
   end

endmodule

// File: rtl/s2a_packer.sv
// Packs accepted I/Q samples into 32-bit words for the S2A stream buffer,
// either one 16-bit pair per word or two rounded 8-bit pairs per word.
module s2a_packer
   import s2a_pkg::*;
#(
   parameter int IW = 12
) (
   input  logic              Sclk,
   input  logic              rst,
   input  logic              sync,
   input  logic              mode,
   input  logic              arm_on_frame,
   s2a_packer_if.slave       bus,
   output logic [SCNT_W-1:0] scnt,
   output logic [SAT_W-1:0]  sat_cnt
);

   state_t              r_state;
   state_t              w_next;
   logic                r_mode;
   logic                r_arm;
   logic                r_pair;
   logic                r_oen;
   logic [15:0]         r_held;
   logic [WORD_W-1:0]   r_odata;

   logic                w_clear;
   logic                w_accept;
   logic [7:0]          w_i8;
   logic [7:0]          w_q8;
   logic                w_isat;
   logic                w_qsat;
   logic [SAT_W:0]      w_satSum;
   logic [SAT_W-1:0]    w_satNext;

   assign w_clear = rst | sync;

   iq_round_sat #(.IW(IW)) u_sat_i (.i_x(bus.in_i), .o_x8(w_i8), .o_sat(w_isat));
   iq_round_sat #(.IW(IW)) u_sat_q (.i_x(bus.in_q), .o_x8(w_q8), .o_sat(w_qsat));

   always_comb begin
      w_next   = r_state;
      w_accept = 1'b0;
      case (r_state)
         IDLE: w_next = r_arm ? WAIT_FRAME : RUN;
         WAIT_FRAME: begin
            if (bus.in_valid && bus.in_frame) begin
               w_accept = 1'b1;
               w_next   = RUN;
            end
         end
         RUN: w_accept = bus.in_valid;
         default: w_next = IDLE;
      endcase
   end

   always_ff @(posedge Sclk) begin
      if (w_clear) r_state <= IDLE;
      else         r_state <= w_next;
   end

   // Configuration is only sampled while the block is held in reset/resync.
   always_ff @(posedge Sclk) begin
      if (w_clear) begin
         r_mode <= mode;
         r_arm  <= arm_on_frame;
      end
   end

   always_comb begin
      w_satSum  = {1'b0, sat_cnt} + (SAT_W+1)'(w_isat) + (SAT_W+1)'(w_qsat);
      w_satNext = w_satSum[SAT_W] ? '1 : w_satSum[SAT_W-1:0];
   end

   always_ff @(posedge Sclk) begin
      if (w_clear) begin
         r_oen   <= 1'b0;
         r_odata <= '0;
         r_pair  <= 1'b0;
         r_held  <= '0;
         scnt    <= '0;
         sat_cnt <= '0;
      end else begin
         r_oen <= 1'b0;
         if (w_accept) begin
            scnt <= scnt + SCNT_W'(1);
            if (r_mode == MODE_16) begin
               r_odata <= {16'($signed(bus.in_q)), 16'($signed(bus.in_i))};
               r_oen   <= 1'b1;
            end else begin
               sat_cnt <= w_satNext;
               if (!r_pair) begin
                  r_held <= {w_q8, w_i8};
                  r_pair <= 1'b1;
               end else begin
                  r_odata <= {w_q8, w_i8, r_held};
                  r_oen   <= 1'b1;
                  r_pair  <= 1'b0;
               end
            end
         end
      end
   end

   // A strobe falling due while reset/resync is held must not reach the controller.
   assign bus.Odata = r_odata;
   assign bus.Oen   = r_oen & ~w_clear;

endmodule
